// File: rtl/mem32_seq8.sv
// Word-to-byte access sequencer: one 32-bit read/write request is serialized
// into four little-endian byte cycles on a single-port, 1-cycle-latency byte memory.
module mem32_seq8 #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [3:0]    bmsk,
    input  logic [AW-3:0] ai,
    input  logic [31:0]   vi,
    output logic          ready,
    output logic          ack,
    output logic [31:0]   vo,
    output logic          m_we,
    output logic [AW-1:0] m_ai,
    output logic [7:0]    m_vi,
    input  logic [7:0]    m_vo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        TAIL  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        r_state;
    logic [1:0]    r_k;
    logic          r_we;
    logic [3:0]    r_bmsk;
    logic [AW-3:0] r_ai;
    logic [31:0]   r_vi;
    logic [31:0]   r_vo;
    logic          r_m_we;
    logic [AW-1:0] r_m_ai;
    logic [7:0]    r_m_vi;

    logic          w_accept;
    logic [1:0]    w_k_next;
    logic [1:0]    w_cap_idx;

    assign ready     = (r_state == IDLE) || (r_state == ACK);
    assign ack       = (r_state == ACK);
    assign w_accept  = req && ready;
    assign w_k_next  = r_k + 2'd1;
    // Read data for byte k arrives one cycle after it was presented.
    assign w_cap_idx = r_k - 2'd1;

    assign vo   = r_vo;
    assign m_we = r_m_we;
    assign m_ai = r_m_ai;
    assign m_vi = r_m_vi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_we    <= 1'b0;
            r_bmsk  <= 4'd0;
            r_ai    <= '0;
            r_vi    <= 32'd0;
            r_vo    <= 32'd0;
            r_m_we  <= 1'b0;
            r_m_ai  <= '0;
            r_m_vi  <= 8'd0;
        end else begin
            r_m_we <= 1'b0;
            case (r_state)
                IDLE, ACK: begin
                    if (w_accept) begin
                        r_state <= ISSUE;
                        r_k     <= 2'd0;
                        r_we    <= we;
                        r_bmsk  <= bmsk;
                        r_ai    <= ai;
                        r_vi    <= vi;
                        // Byte 0 goes out in the first ISSUE cycle, so load it at accept.
                        r_m_ai  <= {ai, 2'b00};
                        r_m_we  <= we & bmsk[0];
                        r_m_vi  <= vi[7:0];
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_k <= w_k_next;
                    if (!r_we && (r_k != 2'd0)) begin
                        r_vo[{w_cap_idx, 3'b000} +: 8] <= m_vo;
                    end
                    if (r_k == 2'd3) begin
                        r_state <= r_we ? ACK : TAIL;
                    end else begin
                        r_m_ai <= {r_ai, w_k_next};
                        r_m_we <= r_we & r_bmsk[w_k_next];
                        r_m_vi <= r_vi[{w_k_next, 3'b000} +: 8];
                    end
                end
                TAIL: begin
                    r_vo[31:24] <= m_vo;
                    r_state     <= ACK;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem32_seq8.sv
// Bench for mem32_seq8: byte RAM behind the DUT, word-level reference model,
// directed test-plan steps followed by randomized transactions.
module tb_mem32_seq8;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    bmsk = 4'd0;
    logic [AW-3:0] ai = '0;
    logic [31:0]   vi = 32'd0;
    logic          ready;
    logic          ack;
    logic [31:0]   vo;
    logic          m_we;
    logic [AW-1:0] m_ai;
    logic [7:0]    m_vi;
    logic [7:0]    m_vo = 8'd0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem   [0:(2**AW)-1];
    logic [7:0] model [0:(2**AW)-1];
    logic [AW-3:0] pool [0:7];

    mem32_seq8 #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .bmsk(bmsk), .ai(ai), .vi(vi),
        .ready(ready), .ack(ack), .vo(vo),
        .m_we(m_we), .m_ai(m_ai), .m_vi(m_vi), .m_vo(m_vo)
    );

    always #5 clk = ~clk;

    // Byte RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (m_we) mem[m_ai] <= m_vi;
        m_vo <= mem[m_ai];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [AW-3:0] a);
        return {model[{a, 2'd3}], model[{a, 2'd2}], model[{a, 2'd1}], model[{a, 2'd0}]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-3:0] a);
        return {mem[{a, 2'd3}], mem[{a, 2'd2}], mem[{a, 2'd1}], mem[{a, 2'd0}]};
    endfunction

    // Called at a falling edge with the DUT ready; returns at the falling edge of the ack cycle.
    task automatic xfer(input logic w, input logic [3:0] bm, input logic [AW-3:0] a,
                        input logic [31:0] d, input bit keep, output logic [31:0] rd);
        logic [31:0]   exp_rd;
        logic [AW-1:0] exp_ai;
        exp_rd = model_word(a);
        chk("ready_before_req", 32'(ready), 32'd1);
        req = 1'b1; we = w; bmsk = bm; ai = a; vi = d;
        @(posedge clk); #1;
        // Keep req high with junk so busy-time requests must be ignored.
        we = 1'($urandom); bmsk = 4'($urandom); ai = (AW-2)'($urandom); vi = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_ai = {a, 2'(k)};
            chk("m_ai", 32'(m_ai), 32'(exp_ai));
            chk("m_we", 32'(m_we), 32'(w & bm[k]));
            if (w) chk("m_vi", 32'(m_vi), 32'(d[8*k +: 8]));
            chk("ack_busy", 32'(ack), 32'd0);
            chk("ready_busy", 32'(ready), 32'd0);
        end
        if (!w) begin
            @(negedge clk);
            chk("ack_tail", 32'(ack), 32'd0);
            chk("m_we_tail", 32'(m_we), 32'd0);
        end
        @(negedge clk);
        chk("ack", 32'(ack), 32'd1);
        chk("ready_in_ack", 32'(ready), 32'd1);
        chk("m_we_ack", 32'(m_we), 32'd0);
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (bm[k]) model[{a, 2'(k)}] = d[8*k +: 8];
            rd = 32'd0;
        end else begin
            chk("vo", vo, exp_rd);
            rd = vo;
        end
        $display("xfer we=%0d bmsk=%h ai=%h vi=%h rd=%h", w, bm, a, d, rd);
        if (!keep) req = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_ack"},   32'(ack),   32'd0);
        chk({tag, "_vo"},    vo,         32'd0);
        chk({tag, "_m_we"},  32'(m_we),  32'd0);
        chk({tag, "_m_ai"},  32'(m_ai),  32'd0);
        chk({tag, "_m_vi"},  32'(m_vi),  32'd0);
    endtask

    task automatic mem_scan();
        for (int i = 0; i < 8; i++)
            chk("mem_scan", mem_word(pool[i]), model_word(pool[i]));
    endtask

    initial begin
        logic [31:0]   rd;
        logic [AW-3:0] amax;
        logic [AW-3:0] a_rst;
        bit            w;

        for (int i = 0; i < 2**AW; i++) begin
            mem[i]   = 8'd0;
            model[i] = 8'd0;
        end
        amax  = '1;
        a_rst = 15'h0050;
        pool[0] = 15'h0010; pool[1] = 15'h0020; pool[2] = 15'h0030; pool[3] = amax;
        pool[4] = 15'h0000; pool[5] = 15'h1234; pool[6] = a_rst;     pool[7] = 15'h4001;

        // Reset state
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full write then read
        xfer(1'b1, 4'hF, 15'h0010, 32'hDEADBEEF, 1'b0, rd);
        @(negedge clk);
        xfer(1'b0, 4'h0, 15'h0010, 32'h0, 1'b0, rd);
        chk("full_readback", rd, 32'hDEADBEEF);
        @(negedge clk);
        chk("vo_hold", vo, 32'hDEADBEEF);
        chk("single_ack", 32'(ack), 32'd0);

        // Partial write
        xfer(1'b1, 4'hF, 15'h0020, 32'h11223344, 1'b0, rd);
        @(negedge clk);
        xfer(1'b1, 4'b0101, 15'h0020, 32'hAABBCCDD, 1'b0, rd);
        @(negedge clk);
        xfer(1'b0, 4'h0, 15'h0020, 32'h0, 1'b0, rd);
        chk("partial_readback", rd, 32'h11BB33DD);
        @(negedge clk);

        // Back-to-back alternating write/read with req held high
        for (int i = 0; i < 6; i++) begin
            w = (i % 2) == 0;
            xfer(w, 4'hF, 15'h0030, $urandom, (i != 5), rd);
        end
        chk("b2b_last_read", rd, model_word(15'h0030));
        @(negedge clk);

        // Busy rejection is exercised by req=1 during every transfer; confirm memory untouched
        mem_scan();

        // Reset mid-write
        xfer(1'b1, 4'hF, a_rst, 32'h55667788, 1'b0, rd);
        @(negedge clk);
        req = 1'b1; we = 1'b1; bmsk = 4'hF; ai = a_rst; vi = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_c3_m_ai", 32'(m_ai), 32'({a_rst, 2'd2}));
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        chk("rst_hold_ack", 32'(ack), 32'd0);
        chk("rst_hold_m_we", 32'(m_we), 32'd0);
        rst_n = 1'b1;
        model[{a_rst, 2'd0}] = 8'h0D;
        model[{a_rst, 2'd1}] = 8'hF0;
        xfer(1'b0, 4'h0, a_rst, 32'h0, 1'b0, rd);
        chk("rst_partial_readback", rd, 32'h5566F00D);
        @(negedge clk);

        // Address wrap at the top word
        xfer(1'b1, 4'hF, amax, 32'h01020304, 1'b0, rd);
        @(negedge clk);
        xfer(1'b0, 4'h0, amax, 32'h0, 1'b0, rd);
        chk("wrap_readback", rd, 32'h01020304);
        chk("wrap_top_byte", 32'(mem[(2**AW)-1]), 32'h01);
        @(negedge clk);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), 4'($urandom), pool[$urandom_range(0, 7)], $urandom,
                 1'($urandom), rd);
            if (!req) @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);
        mem_scan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
